// File: rtl/accumulator_pkg.sv
// Types and constants shared by the accumulator family.
// The differentiator uses them to undo an upstream running total.
package accumulator_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] data;
        logic                     wrap;
    } delta_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry output stage: an output register plus one skid register.
// in_ready is registered and is high exactly when the skid is empty.
module skid_buffer
    import accumulator_pkg::*;
#(
    parameter type T = delta_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic in_valid,
    input  T     in_data,
    output logic in_ready,
    output logic out_valid,
    output T     out_data,
    input  logic out_ready
);

    logic out_valid_reg, out_valid_next;
    T     out_data_reg, out_data_next;
    logic skid_valid_reg, skid_valid_next;
    T     skid_data_reg, skid_data_next;
    logic ready_reg, ready_next;
    logic push;
    logic pop;

    // A push is only possible while the skid is empty, so a full skid never
    // competes with new data for the output register.
    assign push = in_valid && ready_reg;
    assign pop  = out_valid_reg && out_ready;

    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (clear) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            if (pop) begin
                if (skid_valid_reg) begin
                    out_data_next   = skid_data_reg;
                    skid_valid_next = 1'b0;
                end else begin
                    out_valid_next = 1'b0;
                end
            end
            if (push) begin
                if (!out_valid_reg || pop) begin
                    out_valid_next = 1'b1;
                    out_data_next  = in_data;
                end else begin
                    skid_valid_next = 1'b1;
                    skid_data_next  = in_data;
                end
            end
        end
        ready_next = !skid_valid_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            ready_reg      <= 1'b1;
        end else begin
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            ready_reg      <= ready_next;
        end
    end

    assign in_ready  = ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: rtl/differentiator.sv
// Turns a stream of running totals back into per-sample increments,
// modulo 2^WIDTH, with a registered valid/ready output stage.
module differentiator
    import accumulator_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter bit FIRST_ABSOLUTE = 1'b1
) (
    input  logic             i_CLK,
    input  logic             i_RESET_N,
    input  logic             i_CLEAR,
    input  logic             i_ENABLE,
    input  logic [WIDTH-1:0] i_DATA_IN,
    output logic             o_READY,
    output logic             o_VALID,
    output logic [WIDTH-1:0] o_DATA_OUT,
    output logic             o_WRAP,
    input  logic             i_READY
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             wrap;
    } delta_w_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] prev_reg, prev_next;
    logic             skid_ready;
    logic             accept;
    logic             emit;
    delta_w_t         delta;
    delta_w_t         out_delta;

    assign accept = i_ENABLE && skid_ready && !i_CLEAR;
    assign emit   = accept && ((state_reg == RUN) || FIRST_ABSOLUTE);

    // prev is zero while priming, so the first absolute delta falls out of the
    // same subtractor with wrap forced low.
    assign delta.data = i_DATA_IN - prev_reg;
    assign delta.wrap = (i_DATA_IN < prev_reg);

    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        if (i_CLEAR) begin
            state_next = PRIME;
            prev_next  = '0;
        end else if (accept) begin
            state_next = RUN;
            prev_next  = i_DATA_IN;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state_reg <= PRIME;
            prev_reg  <= '0;
        end else begin
            state_reg <= state_next;
            prev_reg  <= prev_next;
        end
    end

    skid_buffer #(
        .T(delta_w_t)
    ) u_skid (
        .clk       (i_CLK),
        .rst_n     (i_RESET_N),
        .clear     (i_CLEAR),
        .in_valid  (emit),
        .in_data   (delta),
        .in_ready  (skid_ready),
        .out_valid (o_VALID),
        .out_data  (out_delta),
        .out_ready (i_READY)
    );

    assign o_READY    = skid_ready;
    assign o_DATA_OUT = out_delta.data;
    assign o_WRAP     = out_delta.wrap;

endmodule

// File: tb/tb_differentiator.sv
// Scoreboard bench: a reference model predicts deltas on every accepted
// sample and a monitor compares them against each downstream transfer.
module tb_differentiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_clear = 1'b0, a_enable = 1'b0, a_i_ready = 1'b1;
    logic [31:0] a_data = '0;
    logic        a_o_ready, a_o_valid, a_o_wrap;
    logic [31:0] a_o_data;

    logic        b_clear = 1'b0, b_enable = 1'b0, b_i_ready = 1'b1;
    logic [31:0] b_data = '0;
    logic        b_o_ready, b_o_valid, b_o_wrap;
    logic [31:0] b_o_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    differentiator #(.WIDTH(32), .FIRST_ABSOLUTE(1'b1)) dut_a (
        .i_CLK(clk), .i_RESET_N(rst_n), .i_CLEAR(a_clear), .i_ENABLE(a_enable),
        .i_DATA_IN(a_data), .o_READY(a_o_ready), .o_VALID(a_o_valid),
        .o_DATA_OUT(a_o_data), .o_WRAP(a_o_wrap), .i_READY(a_i_ready)
    );

    differentiator #(.WIDTH(32), .FIRST_ABSOLUTE(1'b0)) dut_b (
        .i_CLK(clk), .i_RESET_N(rst_n), .i_CLEAR(b_clear), .i_ENABLE(b_enable),
        .i_DATA_IN(b_data), .o_READY(b_o_ready), .o_VALID(b_o_valid),
        .o_DATA_OUT(b_o_data), .o_WRAP(b_o_wrap), .i_READY(b_i_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected delta = sample - baseline (mod 2^32).
    typedef struct packed {
        logic [31:0] data;
        logic        wrap;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] model_base = '0;
    bit          model_primed = 1'b0;
    bit          stall_seen = 1'b0;
    logic [31:0] stall_data = '0;
    logic        stall_wrap = 1'b0;
    int          out_count = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_base   = '0;
                model_primed = 1'b0;
                stall_seen   = 1'b0;
            end else begin
                if (stall_seen) begin
                    check("hold_valid", {63'd0, a_o_valid}, 64'd1);
                    check("hold_data", {32'd0, a_o_data}, {32'd0, stall_data});
                    check("hold_wrap", {63'd0, a_o_wrap}, {63'd0, stall_wrap});
                end
                if (a_o_valid && a_i_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=%08h required=none", a_o_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("delta_data", {32'd0, a_o_data}, {32'd0, e.data});
                        check("delta_wrap", {63'd0, a_o_wrap}, {63'd0, e.wrap});
                    end
                    out_count++;
                    $display("xfer delta=%08h wrap=%0d", a_o_data, a_o_wrap);
                end
                stall_seen = a_o_valid && !a_i_ready && !a_clear;
                stall_data = a_o_data;
                stall_wrap = a_o_wrap;
                if (a_clear) begin
                    exp_q.delete();
                    model_base   = '0;
                    model_primed = 1'b0;
                end else if (a_enable && a_o_ready) begin
                    exp_q.push_back('{data: a_data - model_base, wrap: (a_data < model_base)});
                    model_base   = a_data;
                    model_primed = 1'b1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] t1_in  [4] = '{32'd10, 32'd15, 32'd15, 32'd40};
    logic [31:0] t1_exp [4] = '{32'd10, 32'd5, 32'd0, 32'd25};
    int          acc;
    int          base_cnt;
    logic [31:0] nxt;
    logic        rdy;

    initial begin
        // Reset values
        repeat (2) tick();
        check("rst_valid", {63'd0, a_o_valid}, 64'd0);
        check("rst_data", {32'd0, a_o_data}, 64'd0);
        check("rst_wrap", {63'd0, a_o_wrap}, 64'd0);
        check("rst_ready", {63'd0, a_o_ready}, 64'd1);
        rst_n = 1'b1;
        tick();

        // FIRST_ABSOLUTE=0: first sample is a silent baseline
        b_enable = 1'b1; b_data = 32'd100;
        tick();
        check("b_prime_novalid", {63'd0, b_o_valid}, 64'd0);
        b_data = 32'd103;
        tick();
        check("b_valid", {63'd0, b_o_valid}, 64'd1);
        check("b_delta", {32'd0, b_o_data}, 64'd3);
        check("b_wrap", {63'd0, b_o_wrap}, 64'd0);
        b_enable = 1'b0;

        // Basic stream, one-cycle latency
        for (int k = 0; k < 4; k++) begin
            a_enable = 1'b1; a_data = t1_in[k];
            tick();
            check("t1_valid", {63'd0, a_o_valid}, 64'd1);
            check("t1_data", {32'd0, a_o_data}, {32'd0, t1_exp[k]});
            check("t1_wrap", {63'd0, a_o_wrap}, 64'd0);
        end

        // Upstream wrap-around
        a_data = 32'hFFFF_FFFE;
        tick();
        a_data = 32'h0000_0005;
        tick();
        check("wrap_data", {32'd0, a_o_data}, 64'd7);
        check("wrap_flag", {63'd0, a_o_wrap}, 64'd1);
        a_enable = 1'b0;
        tick();

        // Randomized traffic with backpressure and occasional clears
        for (int n = 0; n < 400; n++) begin
            a_enable  = ($urandom_range(0, 3) != 0);
            a_i_ready = ($urandom_range(0, 3) != 0);
            a_clear   = ($urandom_range(0, 40) == 0);
            a_data    = ($urandom_range(0, 1) == 0) ? $urandom() : a_data + $urandom_range(0, 20);
            tick();
        end
        a_enable = 1'b0; a_clear = 1'b0; a_i_ready = 1'b1;
        repeat (4) tick();
        check("rand_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: 1,2,3,4 against a stalled sink
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        a_i_ready = 1'b0; a_enable = 1'b1; nxt = 32'd1; a_data = nxt; acc = 0;
        base_cnt = out_count;
        for (int c = 0; c < 14; c++) begin
            if (c == 6) begin
                check("bp_accepted", 64'(acc), 64'd2);
                check("bp_ready_low", {63'd0, a_o_ready}, 64'd0);
                check("bp_hold_valid", {63'd0, a_o_valid}, 64'd1);
                check("bp_hold_data", {32'd0, a_o_data}, 64'd1);
                a_i_ready = 1'b1;
            end
            rdy = a_o_ready;
            tick();
            if (rdy && a_enable) begin
                acc++;
                if (nxt == 32'd4) a_enable = 1'b0;
                else begin
                    nxt = nxt + 32'd1;
                    a_data = nxt;
                end
            end
        end
        a_enable = 1'b0;
        repeat (3) tick();
        check("bp_total_accepted", 64'(acc), 64'd4);
        check("bp_out_count", 64'(out_count - base_cnt), 64'd4);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Clear with full skid and a same-cycle sample
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0; a_i_ready = 1'b0; a_enable = 1'b1; a_data = 32'd20;
        tick();
        a_data = 32'd30;
        tick();
        check("clr_setup_full", {63'd0, a_o_ready}, 64'd0);
        a_clear = 1'b1; a_data = 32'd50;
        tick();
        check("clr_valid", {63'd0, a_o_valid}, 64'd0);
        check("clr_ready", {63'd0, a_o_ready}, 64'd1);
        a_clear = 1'b0; a_i_ready = 1'b1; a_data = 32'd7;
        tick();
        check("clr_first_valid", {63'd0, a_o_valid}, 64'd1);
        check("clr_first_data", {32'd0, a_o_data}, 64'd7);
        a_enable = 1'b0;
        tick();

        // Asynchronous reset between edges
        a_i_ready = 1'b0; a_enable = 1'b1; a_data = 32'd100;
        tick();
        a_data = 32'd200;
        tick();
        a_enable = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, a_o_valid}, 64'd0);
        check("arst_data", {32'd0, a_o_data}, 64'd0);
        check("arst_wrap", {63'd0, a_o_wrap}, 64'd0);
        check("arst_ready", {63'd0, a_o_ready}, 64'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        a_i_ready = 1'b1; a_enable = 1'b1; a_data = 32'd9;
        tick();
        check("arst_first_valid", {63'd0, a_o_valid}, 64'd1);
        check("arst_first_data", {32'd0, a_o_data}, 64'd9);
        a_enable = 1'b0;
        repeat (3) tick();
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/differentiator.md
# differentiator

Streaming inverse of the accumulator: accepts a stream of running totals and emits the per-sample difference `x[n] - x[n-1]` (modulo 2^WIDTH). Because the subtraction is modular, it recovers the exact increments fed into an upstream accumulator, including across accumulator wrap-around. It sits on the consumer side of accumulator outputs, for example in checkers, rate meters and decimated-total reconstruction. Output is registered, with valid/ready backpressure absorbed by a 2-entry skid stage.

## Interface
- `WIDTH`, 32, data width of totals and deltas
- `FIRST_ABSOLUTE`, 1, first accepted sample after reset/clear: 1 = emit `sample - 0`; 0 = consume silently as baseline
- `i_CLK`  in  1  clock, all state on rising edge
- `i_RESET_N`  in  1  one clock; reset is asynchronous and active-low
- `i_CLEAR`  in  1  synchronous flush/rebaseline, highest priority after reset
- `i_ENABLE`  in  1  input sample valid
- `i_DATA_IN`  in  WIDTH  running total sample
- `o_READY`  out  1  registered; input accepted when `i_ENABLE && o_READY`
- `o_VALID`  out  1  output delta valid
- `o_DATA_OUT`  out  WIDTH  delta, two's-complement modulo 2^WIDTH
- `o_WRAP`  out  1  qualifies `o_DATA_OUT`: sample < previous (unsigned), i.e. upstream wrapped
- `i_READY`  in  1  downstream ready; transfer when `o_VALID && i_READY`

## Operation
- States: PRIME (no baseline held) and RUN. Reset and `i_CLEAR` go to PRIME with `prev = 0`.
- Accept in PRIME: `prev <= data`; go to RUN. If `FIRST_ABSOLUTE`, emit `{delta=data, wrap=0}`; otherwise emit nothing.
- Accept in RUN: emit `{delta=data-prev, wrap=(data<prev)}`; `prev <= data`.
- Arithmetic: WIDTH-bit unsigned subtract, carry discarded, no saturation. Example: `0x0000_0005 - 0xFFFF_FFFE = 0x0000_0007` with `wrap=1`.
- Equal samples give `delta=0`, `wrap=0`. Both are still emitted.
- Output path: output register plus one skid register.
  - A new delta goes to the output register if it is empty or is transferring this cycle; otherwise it goes to the skid.
  - On transfer with the skid full, the skid moves to the output register.
- `o_READY` is 1 exactly when the skid is empty, registered. Input therefore never overruns: at most one beat is in flight when `o_READY` falls.
- `i_CLEAR`:
  - Drops the output and skid contents (`o_VALID <= 0`), sets `o_READY <= 1`, and returns to PRIME.
  - A sample presented in the same cycle is discarded.
  - A downstream transfer in that cycle still counts as completed.
- `i_ENABLE` while `o_READY=0` is ignored. `prev` is not updated.

## Timing
- Reset values: `o_VALID=0`, `o_DATA_OUT=0`, `o_WRAP=0`, `o_READY=1`, state=PRIME, `prev=0`, skid empty.
- Asynchronous assert; deasserted on a clock edge. Reset mid-stream loses all in-flight deltas.
- Latency: accept at edge N gives `o_VALID` after edge N with the delta (1 cycle). Throughput is 1/cycle while `i_READY=1`.
- `o_VALID`, `o_DATA_OUT` and `o_WRAP` hold stable while `o_VALID && !i_READY`.
- Backpressure: with the output held and one more accept, the skid fills and `o_READY=0` from the next cycle. `o_READY` returns to 1 the cycle after the skid drains.
- No combinational path from `i_READY` or `i_ENABLE` to any output.

## Structure
- Shared package `accumulator_pkg`:
  - `DEFAULT_WIDTH = 32`
  - state enum {PRIME, RUN}
  - struct `delta_t` {data, wrap}
- Sub-module `skid_buffer` (parameterised payload `delta_t`, 2 entries, registered ready). The top holds the FSM, `prev` and the subtractor.

## Test plan
- Reset, `FIRST_ABSOLUTE=1`, inputs 10, 15, 15, 40 with `i_READY=1`: outputs 10, 5, 0, 25, each 1 cycle after accept, all with `wrap=0`.
- `FIRST_ABSOLUTE=0`, inputs 100, 103: 100 produces no output; 103 produces 3.
- Wrap: inputs `0xFFFF_FFFE`, `0x0000_0005`: second output is `0x0000_0007` with `wrap=1`.
- Backpressure:
  - Setup: `i_READY=0`, `i_ENABLE=1` continuously with inputs 1, 2, 3, 4.
  - Exactly 2 are accepted and `o_READY` falls; outputs hold 1.
  - Then `i_READY=1`: deltas 1, 1, 1, 1 in order, none lost or duplicated.
- `i_CLEAR` with a full skid and a same-cycle input of 50:
  - Next cycle: `o_VALID=0`, `o_READY=1`, state PRIME, 50 dropped.
  - Next input 7 emits 7.
- Async reset asserted mid-burst between edges: outputs go to reset values immediately. After release, input 9 emits 9 (`FIRST_ABSOLUTE=1`).
